// File: rtl/abc_seq_driver_pkg.sv
// Shared types for the a->b->c sequence driver: command kinds, FSM states
// and the queued command payload.
package abc_seq_pkg;

  localparam int unsigned GAP_W      = 4;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    DROP_B = 2'd1,
    DROP_C = 2'd2,
    RSVD   = 2'd3
  } cmd_kind_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH_A = 3'd1,
    PH_B = 3'd2,
    PH_C = 3'd3,
    GAP  = 3'd4
  } state_e;

  typedef struct packed {
    cmd_kind_e        kind;
    logic [GAP_W-1:0] gap;
  } seq_cmd_t;

  // The reserved kind behaves exactly like PASS downstream.
  function automatic seq_cmd_t normalize_cmd(seq_cmd_t cmd);
    seq_cmd_t r;
    r = cmd;
    if (cmd.kind == RSVD) r.kind = PASS;
    return r;
  endfunction

  function automatic logic kind_is_fail(cmd_kind_e kind);
    return (kind == DROP_B) || (kind == DROP_C);
  endfunction

endpackage

// File: rtl/abc_seq_driver_if.sv
// Command / pulse / status bundle between the stimulus source and the driver.
interface abc_seq_driver_if;
  import abc_seq_pkg::*;

  logic             enable;
  logic             cmd_valid;
  logic             cmd_ready;
  cmd_kind_e        cmd_kind;
  logic [GAP_W-1:0] cmd_gap;
  logic             a;
  logic             b;
  logic             c;
  logic             seq_done;
  logic             busy;
  logic [CNT_W-1:0] seq_count;
  logic [CNT_W-1:0] exp_fail_count;

  modport master (
    output enable, cmd_valid, cmd_kind, cmd_gap,
    input  cmd_ready, a, b, c, seq_done, busy, seq_count, exp_fail_count
  );

  modport slave (
    input  enable, cmd_valid, cmd_kind, cmd_gap,
    output cmd_ready, a, b, c, seq_done, busy, seq_count, exp_fail_count
  );

endinterface

// File: rtl/abc_seq_cmd_fifo.sv
// Synchronous show-ahead FIFO of sequence commands; pop while empty and push
// while full are ignored.
module abc_seq_cmd_fifo
  import abc_seq_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  seq_cmd_t wdata,
  output seq_cmd_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  seq_cmd_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/abc_seq_driver.sv
// Replays queued commands as one-cycle a, b, c pulse trains with optional
// idle gaps, and counts issued and expected-failing sequences.
module abc_seq_driver
  import abc_seq_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  abc_seq_driver_if.slave  bus
);

  state_e           state_q, state_d;
  seq_cmd_t         cur_q, cur_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] seq_count_q, seq_count_d;
  logic [CNT_W-1:0] exp_fail_q, exp_fail_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             c_q, c_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             fifo_full, fifo_empty;
  logic             push_c, pop_c, can_start_c, leave_c;
  seq_cmd_t         head, wr_cmd;

  assign wr_cmd.kind = bus.cmd_kind;
  assign wr_cmd.gap  = bus.cmd_gap;
  assign push_c      = bus.cmd_valid && !fifo_full;
  assign can_start_c = bus.enable && !fifo_empty;

  abc_seq_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (wr_cmd),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, gap counter and counter updates.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    gap_cnt_d   = gap_cnt_q;
    seq_count_d = seq_count_q;
    exp_fail_d  = exp_fail_q;
    pop_c       = 1'b0;
    leave_c     = 1'b0;

    case (state_q)
      IDLE: leave_c = 1'b1;
      PH_A: state_d = PH_B;
      PH_B: state_d = PH_C;
      PH_C: begin
        seq_count_d = seq_count_q + CNT_W'(1);
        if (kind_is_fail(cur_q.kind)) exp_fail_d = exp_fail_q + CNT_W'(1);
        if (cur_q.gap != '0) begin
          gap_cnt_d = cur_q.gap - GAP_W'(1);
          state_d   = GAP;
        end else begin
          leave_c = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) leave_c = 1'b1;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Common exit: start the next queued command or fall back to IDLE.
    if (leave_c) begin
      if (can_start_c) begin
        pop_c   = 1'b1;
        cur_d   = normalize_cmd(head);
        state_d = PH_A;
      end else begin
        state_d = IDLE;
      end
    end

    // Pulses are a registered decode of the current state, trailing the FSM
    // by one cycle; busy trails the same way so it covers the last pulse.
    a_d    = (state_q == PH_A);
    b_d    = (state_q == PH_B) && (cur_q.kind != DROP_B);
    c_d    = (state_q == PH_C) && (cur_q.kind == PASS);
    done_d = (state_q == PH_C);
    busy_d = (state_q != IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      gap_cnt_q   <= '0;
      seq_count_q <= '0;
      exp_fail_q  <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      c_q         <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      gap_cnt_q   <= gap_cnt_d;
      seq_count_q <= seq_count_d;
      exp_fail_q  <= exp_fail_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready      = !fifo_full;
  assign bus.a              = a_q;
  assign bus.b              = b_q;
  assign bus.c              = c_q;
  assign bus.seq_done       = done_q;
  assign bus.busy           = busy_q;
  assign bus.seq_count      = seq_count_q;
  assign bus.exp_fail_count = exp_fail_q;

endmodule
